wireframe_edge_rasterizer: RTL and testbench
============================================

// Module: wireframe_edge_rasterizer
// PURPOSE
//  Parametrised successor to the fixed-size wireframe rasterizer. Takes one screen-space
//  triangle, walks its three edges P0->P1, P1->P2, P2->P0 with integer Bresenham, and emits
//  one framebuffer write per on-screen pixel as a linear address. Adds a write_ready
//  backpressure handshake and clips off-screen pixels. Sits between the projection stage
//  and the wireframe framebuffer write port.
// PARAMETERS
//  WIDTH    640  screen width in pixels
//  HEIGHT   480  screen height in pixels
//  COORD_W  12   signed two's-complement width of each vertex coordinate
//  ADDR_W   19   framebuffer address width, >= clog2(WIDTH*HEIGHT)
//  PIX_W    1    pixel data width (1 = monochrome wireframe)
// PORTS
//  clk         in   1        clock, rising edge
//  n_rst       in   1        asynchronous active-low reset
//  start       in   1        request; sampled only in IDLE
//  p0_x..p2_y  in   COORD_W  six signed vertex coordinates; latched when start accepted
//  pix_data    in   PIX_W    pixel value; latched when start accepted
//  write_ready in   1        framebuffer accepts the current write this cycle
//  write_en    out  1        write valid
//  addr        out  ADDR_W   y*WIDTH + x of current pixel
//  wf_data     out  PIX_W    latched pix_data
//  busy        out  1        high in every state except IDLE
//  done        out  1        one-cycle pulse when the triangle is complete
// BEHAVIOUR
//  - Reset: state IDLE. write_en, addr, wf_data, busy and done are 0. The edge index and the
//    Bresenham registers are cleared.
//  - Reset mid-operation: abort immediately. No done pulse, no further writes.
//  - FSM:
//      IDLE  -start-> SETUP
//      SETUP (1 cycle) -> STEP
//      STEP  -last pixel of edge retired-> SETUP if edge<2, else DONE
//      DONE  (1 cycle, done=1) -> IDLE
//  - start in any state other than IDLE is ignored. Vertex inputs are don't-care after the
//    accept cycle.
//  - SETUP for edge (a->b), with internal width COORD_W+2, signed:
//      dx=|xb-xa|, dy=-|yb-ya|, sx=sign(xb-xa), sy=sign(yb-ya), err=dx+dy
//      current point = (xa,ya)
//  - STEP: the current point is the pixel. It is on-screen when 0<=x<WIDTH and 0<=y<HEIGHT.
//      - On-screen: write_en=1, addr=y*WIDTH+x, wf_data valid.
//      - The pixel retires on the cycle write_en&write_ready. Off-screen pixels retire in
//        1 cycle with write_en=0.
//      - While write_en=1 and write_ready=0, write_en, addr, wf_data and all state hold stable.
//      - On retire: if current==b the edge ends. Otherwise e2=2*err, then:
//          e2>=dy: err+=dy, x+=sx
//          e2<=dx: err+=dx, y+=sy
//        Both updates apply in the same cycle when both conditions hold.
//  - Both endpoints are drawn. Shared vertices are written twice (once per edge).
//  - Degenerate edge (a==b): exactly one pixel.
//  - write_en is registered; first write_en appears in the 2nd cycle after start is sampled.
//  - Throughput: 1 pixel/cycle with write_ready=1. Cycles per edge = 1 + max(dx,-dy) + 1.
//  - done asserts the cycle after the final pixel retires, for exactly one cycle.
//    write_en=0 while done=1.
//  - Coordinates whose intermediate values stay in COORD_W+2 bits never overflow.
//    Vertices beyond +/-2^(COORD_W-1) are unsupported.
// TESTING
//  1. P0=(0,0) P1=(3,0) P2=(0,0), ready=1 -> addr sequence 0,1,2,3 | 3,2,1,0 | 0;
//     9 writes, then done pulse; busy high throughout.
//  2. P0=(3,3) P1=(300,300) P2=(50,150), WIDTH=640 -> first addr 1923; edge0 is 298 writes,
//     stepping +641, ending at 192300; all pixels match a software Bresenham model.
//  3. Case 2 with write_ready random 50% -> identical addr sequence; write_en/addr stable
//     while ready=0; no pixel dropped or duplicated.
//  4. P0=(-2,0) P1=(2,0) P2=(-2,0) -> edge0 writes only addr 0,1,2; off-screen steps show
//     write_en=0; done still pulses.
//  5. n_rst low during edge1 STEP -> all outputs 0 asynchronously, no done; next start
//     renders case 1 correctly.
//  6. start held high through a whole triangle -> exactly one triangle per IDLE entry;
//     done width 1 cycle; start during busy has no effect.

Source files
------------

// File: rtl/wireframe_edge_rasterizer.sv
// -----------------------------------------------------------------------------
// wireframe_edge_rasterizer
//
// Walks the three edges of one screen-space triangle (P0->P1, P1->P2, P2->P0)
// with integer Bresenham. For every on-screen pixel it issues one framebuffer
// write (linear address y*WIDTH+x), honouring write_ready backpressure.
// Off-screen pixels are stepped over in one cycle without a write.
//
// Ports
//   clk          clock, rising edge
//   n_rst        asynchronous active-low reset
//   start        triangle request, only looked at while idle
//   p0_x..p2_y   signed vertex coordinates, captured when start is accepted
//   pix_data     pixel value, captured when start is accepted
//   write_ready  framebuffer takes the current write this cycle
//   write_en     write valid (registered)
//   addr         y*WIDTH + x of the current pixel (registered)
//   wf_data      captured pix_data
//   busy         high in every state except idle
//   done         one-cycle pulse after the last pixel of the triangle retires
// -----------------------------------------------------------------------------
module wireframe_edge_rasterizer #(
    parameter int WIDTH   = 640,
    parameter int HEIGHT  = 480,
    parameter int COORD_W = 12,
    parameter int ADDR_W  = 19,
    parameter int PIX_W   = 1
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               start,
    input  logic [COORD_W-1:0] p0_x,
    input  logic [COORD_W-1:0] p0_y,
    input  logic [COORD_W-1:0] p1_x,
    input  logic [COORD_W-1:0] p1_y,
    input  logic [COORD_W-1:0] p2_x,
    input  logic [COORD_W-1:0] p2_y,
    input  logic [PIX_W-1:0]   pix_data,
    input  logic               write_ready,
    output logic               write_en,
    output logic [ADDR_W-1:0]  addr,
    output logic [PIX_W-1:0]   wf_data,
    output logic               busy,
    output logic               done
);

    // Two guard bits keep |b-a| and the error term free of overflow.
    localparam int CW = COORD_W + 2;
    typedef logic signed [CW-1:0] coord_t;

    localparam coord_t WIDTH_S  = coord_t'(WIDTH);
    localparam coord_t HEIGHT_S = coord_t'(HEIGHT);
    localparam coord_t C_ZERO   = coord_t'(0);
    localparam coord_t C_ONE    = coord_t'(1);
    localparam coord_t C_M_ONE  = coord_t'(-1);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STEP, S_DONE} state_t;

    function automatic coord_t sext(input logic [COORD_W-1:0] v);
        return {{2{v[COORD_W-1]}}, v};
    endfunction

    function automatic logic on_screen(input coord_t x, input coord_t y);
        return !x[CW-1] && (x < WIDTH_S) && !y[CW-1] && (y < HEIGHT_S);
    endfunction

    function automatic logic [ADDR_W-1:0] pix_addr(input coord_t x, input coord_t y);
        return ADDR_W'($unsigned(y)) * ADDR_W'(WIDTH) + ADDR_W'($unsigned(x));
    endfunction

    state_t               state_q, state_d;
    logic [1:0]           edge_idx_q, edge_idx_d;
    logic [COORD_W-1:0]   vx_q [3];
    logic [COORD_W-1:0]   vy_q [3];
    logic [COORD_W-1:0]   vx_d [3];
    logic [COORD_W-1:0]   vy_d [3];
    logic [PIX_W-1:0]     data_q, data_d;
    coord_t               x_q, x_d, y_q, y_d;       // current pixel
    coord_t               xe_q, xe_d, ye_q, ye_d;   // edge end point
    coord_t               dx_q, dx_d, dy_q, dy_d;
    coord_t               sx_q, sx_d, sy_q, sy_d;
    coord_t               err_q, err_d;
    logic                 we_q, we_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;

    // Combinational helpers
    coord_t               ax, ay, bx, by, diff_x, diff_y, abs_x, nabs_y;
    coord_t               nx, ny, nerr;
    logic signed [CW:0]   e2;
    logic                 step_x, step_y, retire, at_end;

    always_comb begin
        state_d    = state_q;
        edge_idx_d = edge_idx_q;
        vx_d       = vx_q;
        vy_d       = vy_q;
        data_d     = data_q;
        x_d        = x_q;
        y_d        = y_q;
        xe_d       = xe_q;
        ye_d       = ye_q;
        dx_d       = dx_q;
        dy_d       = dy_q;
        sx_d       = sx_q;
        sy_d       = sy_q;
        err_d      = err_q;
        we_d       = we_q;
        addr_d     = addr_q;

        // End points of the edge selected by edge_idx_q
        case (edge_idx_q)
            2'd0: begin
                ax = sext(vx_q[0]); ay = sext(vy_q[0]);
                bx = sext(vx_q[1]); by = sext(vy_q[1]);
            end
            2'd1: begin
                ax = sext(vx_q[1]); ay = sext(vy_q[1]);
                bx = sext(vx_q[2]); by = sext(vy_q[2]);
            end
            default: begin
                ax = sext(vx_q[2]); ay = sext(vy_q[2]);
                bx = sext(vx_q[0]); by = sext(vy_q[0]);
            end
        endcase
        diff_x = bx - ax;
        diff_y = by - ay;
        abs_x  = diff_x[CW-1] ? -diff_x : diff_x;
        nabs_y = diff_y[CW-1] ? diff_y : -diff_y;   // dy is kept negative

        // One Bresenham step from the current pixel
        e2     = {err_q, 1'b0};
        step_x = (e2 >= $signed({dy_q[CW-1], dy_q}));
        step_y = (e2 <= $signed({dx_q[CW-1], dx_q}));
        nx     = step_x ? x_q + sx_q : x_q;
        ny     = step_y ? y_q + sy_q : y_q;
        nerr   = err_q;
        if (step_x) nerr = nerr + dy_q;
        if (step_y) nerr = nerr + dx_q;

        // A pixel leaves STEP once written, or immediately when off-screen
        retire = !we_q || write_ready;
        at_end = (x_q == xe_q) && (y_q == ye_q);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    vx_d       = '{p0_x, p1_x, p2_x};
                    vy_d       = '{p0_y, p1_y, p2_y};
                    data_d     = pix_data;
                    edge_idx_d = 2'd0;
                    state_d    = S_SETUP;
                end
            end
            S_SETUP: begin
                dx_d    = abs_x;
                dy_d    = nabs_y;
                sx_d    = diff_x[CW-1] ? C_M_ONE : ((diff_x != C_ZERO) ? C_ONE : C_ZERO);
                sy_d    = diff_y[CW-1] ? C_M_ONE : ((diff_y != C_ZERO) ? C_ONE : C_ZERO);
                err_d   = abs_x + nabs_y;
                x_d     = ax;
                y_d     = ay;
                xe_d    = bx;
                ye_d    = by;
                we_d    = on_screen(ax, ay);
                addr_d  = pix_addr(ax, ay);
                state_d = S_STEP;
            end
            S_STEP: begin
                if (retire) begin
                    if (at_end) begin
                        we_d = 1'b0;
                        if (edge_idx_q == 2'd2) begin
                            edge_idx_d = 2'd0;
                            state_d    = S_DONE;
                        end else begin
                            edge_idx_d = edge_idx_q + 2'd1;
                            state_d    = S_SETUP;
                        end
                    end else begin
                        x_d    = nx;
                        y_d    = ny;
                        err_d  = nerr;
                        we_d   = on_screen(nx, ny);
                        addr_d = pix_addr(nx, ny);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= S_IDLE;
            edge_idx_q <= 2'd0;
            vx_q       <= '{default: '0};
            vy_q       <= '{default: '0};
            data_q     <= '0;
            x_q        <= '0;
            y_q        <= '0;
            xe_q       <= '0;
            ye_q       <= '0;
            dx_q       <= '0;
            dy_q       <= '0;
            sx_q       <= '0;
            sy_q       <= '0;
            err_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            edge_idx_q <= edge_idx_d;
            vx_q       <= vx_d;
            vy_q       <= vy_d;
            data_q     <= data_d;
            x_q        <= x_d;
            y_q        <= y_d;
            xe_q       <= xe_d;
            ye_q       <= ye_d;
            dx_q       <= dx_d;
            dy_q       <= dy_d;
            sx_q       <= sx_d;
            sy_q       <= sy_d;
            err_q      <= err_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
        end
    end

    assign write_en = we_q;
    assign addr     = addr_q;
    assign wf_data  = data_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_wireframe_edge_rasterizer.sv
// -----------------------------------------------------------------------------
// tb_wireframe_edge_rasterizer
//
// Directed and randomized triangles checked against a software Bresenham model
// that produces the expected list of on-screen write addresses and the
// expected cycle count for each triangle.
// -----------------------------------------------------------------------------
module tb_wireframe_edge_rasterizer;

    localparam int W  = 640;
    localparam int H  = 480;
    localparam int CWI = 12;
    localparam int AW = 19;

    logic            clk = 1'b0;
    logic            n_rst;
    logic            start;
    logic [CWI-1:0]  p0_x, p0_y, p1_x, p1_y, p2_x, p2_y;
    logic [0:0]      pix_data;
    logic            write_ready;
    logic            write_en;
    logic [AW-1:0]   addr;
    logic [0:0]      wf_data;
    logic            busy;
    logic            done;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];
    int exp_cycles;

    always #5 clk = ~clk;

    wireframe_edge_rasterizer #(
        .WIDTH(W), .HEIGHT(H), .COORD_W(CWI), .ADDR_W(AW), .PIX_W(1)
    ) dut (
        .clk(clk), .n_rst(n_rst), .start(start),
        .p0_x(p0_x), .p0_y(p0_y), .p1_x(p1_x), .p1_y(p1_y), .p2_x(p2_x), .p2_y(p2_y),
        .pix_data(pix_data), .write_ready(write_ready),
        .write_en(write_en), .addr(addr), .wf_data(wf_data), .busy(busy), .done(done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_v(input int x0, input int y0, input int x1, input int y1,
                         input int x2, input int y2);
        p0_x = CWI'(x0); p0_y = CWI'(y0);
        p1_x = CWI'(x1); p1_y = CWI'(y1);
        p2_x = CWI'(x2); p2_y = CWI'(y2);
    endtask

    // Textbook Bresenham over the three edges; both end points drawn.
    task automatic build_model(input int x0, input int y0, input int x1, input int y1,
                               input int x2, input int y2);
        int vx[3];
        int vy[3];
        vx = '{x0, x1, x2};
        vy = '{y0, y1, y2};
        exp_q.delete();
        exp_cycles = 0;
        for (int e = 0; e < 3; e++) begin
            int xa, ya, xb, yb, dx, dy, sx, sy, err, x, y, e2;
            xa = vx[e]; ya = vy[e];
            xb = vx[(e + 1) % 3]; yb = vy[(e + 1) % 3];
            dx = (xb > xa) ? xb - xa : xa - xb;
            dy = (yb > ya) ? ya - yb : yb - ya;
            sx = (xa < xb) ? 1 : -1;
            sy = (ya < yb) ? 1 : -1;
            err = dx + dy;
            x = xa; y = ya;
            exp_cycles += 2 + ((dx > -dy) ? dx : -dy);
            for (int n = 0; n < 10000; n++) begin
                if (x >= 0 && x < W && y >= 0 && y < H) exp_q.push_back(y * W + x);
                if (x == xb && y == yb) break;
                e2 = 2 * err;
                if (e2 >= dy) begin err += dy; x += sx; end
                if (e2 <= dx) begin err += dx; y += sy; end
            end
        end
    endtask

    task automatic run_tri(input int x0, input int y0, input int x1, input int y1,
                           input int x2, input int y2, input int ready_pct,
                           input bit hold_start, input string name);
        int k, nwr;
        bit done_seen;
        logic prev_we, prev_rdy;
        logic [AW-1:0] prev_addr;
        logic [0:0] pd;
        build_model(x0, y0, x1, y1, x2, y2);
        pd = 1'($urandom_range(0, 1));
        @(negedge clk);
        set_v(x0, y0, x1, y1, x2, y2);
        pix_data = pd;
        start = 1'b1;
        write_ready = 1'b1;
        k = 0; nwr = 0; done_seen = 0;
        prev_we = 1'b0; prev_rdy = 1'b1; prev_addr = '0;
        while (!done_seen && k < 20000) begin
            @(negedge clk);
            k++;
            if (!hold_start) start = 1'b0;
            // Inputs after the accept cycle must not matter
            set_v(int'($urandom), int'($urandom), int'($urandom),
                  int'($urandom), int'($urandom), int'($urandom));
            pix_data = ~pd;
            if (prev_we === 1'b1 && prev_rdy === 1'b0) begin
                check({name, "/hold_we"}, write_en, 1);
                check({name, "/hold_addr"}, addr, prev_addr);
            end
            if (done === 1'b1) begin
                done_seen = 1;
                check({name, "/we_at_done"}, write_en, 0);
                check({name, "/nwrites"}, nwr, exp_q.size());
                if (ready_pct >= 100) check({name, "/done_cycle"}, k, exp_cycles + 1);
                set_v(x0, y0, x1, y1, x2, y2);
                pix_data = pd;
            end else begin
                check({name, "/busy"}, busy, 1);
                write_ready = ($urandom_range(0, 99) < ready_pct);
                if (write_en === 1'b1) begin
                    check({name, "/wf_data"}, wf_data, pd);
                    if (write_ready) begin
                        if (nwr < exp_q.size()) check({name, "/addr"}, addr, exp_q[nwr]);
                        else check({name, "/extra_write"}, nwr, exp_q.size());
                        nwr++;
                    end
                end
            end
            prev_we = write_en; prev_rdy = write_ready; prev_addr = addr;
        end
        check({name, "/done_seen"}, done_seen, 1);
        @(negedge clk);
        check({name, "/done_width"}, done, 0);
        check({name, "/idle_busy"}, busy, 0);
        $display("tri %s writes=%0d expected=%0d cycles=%0d", name, nwr, exp_q.size(), k);
    endtask

    initial begin
        int nw;
        bit seen;
        n_rst = 1'b0;
        start = 1'b0;
        write_ready = 1'b0;
        pix_data = '0;
        set_v(0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        check("rst/write_en", write_en, 0);
        check("rst/addr", addr, 0);
        check("rst/wf_data", wf_data, 0);
        check("rst/busy", busy, 0);
        check("rst/done", done, 0);
        n_rst = 1'b1;
        $display("reset released");

        // Line and its return, plus degenerate closing edge
        run_tri(0, 0, 3, 0, 0, 0, 100, 0, "t1_line");
        // Long diagonal with full throughput, then with backpressure
        run_tri(3, 3, 300, 300, 50, 150, 100, 0, "t2_diag");
        run_tri(3, 3, 300, 300, 50, 150, 50, 0, "t3_bp");
        // Partially off-screen edges
        run_tri(-2, 0, 2, 0, -2, 0, 100, 0, "t4_clip");

        // Reset in the middle of edge 1
        @(negedge clk);
        set_v(0, 0, 3, 0, 0, 0);
        pix_data = 1'b1;
        start = 1'b1;
        write_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        check("t5/edge1_we", write_en, 1);
        check("t5/edge1_addr", addr, 3);
        #2 n_rst = 1'b0;
        #1;
        check("t5/async_we", write_en, 0);
        check("t5/async_addr", addr, 0);
        check("t5/async_wf", wf_data, 0);
        check("t5/async_busy", busy, 0);
        check("t5/async_done", done, 0);
        repeat (3) begin
            @(negedge clk);
            check("t5/no_done", done, 0);
            check("t5/no_write", write_en, 0);
        end
        n_rst = 1'b1;
        $display("reset mid-edge applied");
        run_tri(0, 0, 3, 0, 0, 0, 100, 0, "t5_after_rst");

        // start held: one triangle per idle entry
        run_tri(0, 0, 3, 0, 0, 0, 100, 1, "t6_hold");
        @(negedge clk);
        check("t6/restart_busy", busy, 1);
        start = 1'b0;
        write_ready = 1'b1;
        nw = 0; seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1;
            else if (write_en === 1'b1) nw++;
        end
        check("t6/restart_done", seen, 1);
        check("t6/restart_writes", nw, 9);
        $display("tri t6_restart writes=%0d", nw);

        // Random triangles, some with backpressure
        for (int t = 0; t < 4; t++) begin
            int rx[3];
            int ry[3];
            for (int v = 0; v < 3; v++) begin
                rx[v] = int'($urandom_range(0, 767)) - 64;
                ry[v] = int'($urandom_range(0, 607)) - 64;
            end
            run_tri(rx[0], ry[0], rx[1], ry[1], rx[2], ry[2],
                    (t % 2 == 0) ? 100 : 50, 0, $sformatf("rand%0d", t));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
